ifu_fetch: RTL

//  Instruction-fetch unit directly downstream of the fetch-stage PC register.
//  - Latches the current PC and fetches one 32-bit instruction over an AXI4-Lite read channel (AR/R).
//  - Presents the result to decode through a one-entry valid/ready buffer.
//  - Pulses fetch_done so the controller releases the PC-register stall.
//  - Drops in-flight fetches on a pipeline redirect (flush).

---
 rtl/ifu_fetch.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch unit behind the fetch-stage PC register.
// Latches the PC, issues one AXI4-Lite read (AR then R) and hands the
// instruction to decode through a one-entry valid/ready buffer.
// fetch_done_o pulses on the decode handshake to release the PC stall.
// A flush drops the in-flight fetch or the buffered instruction.
// Optional feature macro: IFU_PERF_EN enables the perf_fetch_o/perf_wait_o
// counters; without it both ports are tied to zero.
module ifu_fetch #(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] FAULT_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              arvalid_o,
    output logic [ADDR_W-1:0] araddr_o,
    input  logic              arready_i,
    input  logic              rvalid_i,
    input  logic [31:0]       rdata_i,
    input  logic [1:0]        rresp_i,
    output logic              rready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_inst_o,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic              out_fault_o,
    output logic              fetch_done_o,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_wait_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_arvalid;
    logic              w_rready;
    logic              w_latch_pc;
    logic              w_capture;
    logic              w_release;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_drop;
    logic              r_out_valid;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_pc;
    logic              r_out_fault;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-state strobes; AR and R are never active together.
    always_comb begin
        w_state_next = r_state;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_latch_pc   = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush_i) begin
                    w_latch_pc   = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                // arvalid is held until the handshake, even across a flush.
                w_arvalid = 1'b1;
                if (arready_i) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                w_rready = 1'b1;
                if (rvalid_i) begin
                    if (r_drop || flush_i) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Flush and a decode handshake both empty the buffer.
                if (flush_i || out_ready_i) begin
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request PC, drop flag and the one-entry output buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc    <= '0;
            r_drop      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
            r_out_fault <= 1'b0;
        end else begin
            if (w_latch_pc) begin
                r_req_pc <= pc_i;
            end
            // A flush while the read is outstanding marks its data as stale.
            if (r_state == S_REQ && flush_i) begin
                r_drop <= 1'b1;
            end else if (r_state == S_WAIT) begin
                if (rvalid_i) begin
                    r_drop <= 1'b0;
                end else if (flush_i) begin
                    r_drop <= 1'b1;
                end
            end
            if (w_capture) begin
                r_out_inst  <= (rresp_i == 2'b00) ? rdata_i : FAULT_INST;
                r_out_pc    <= r_req_pc;
                r_out_fault <= (rresp_i != 2'b00);
                r_out_valid <= 1'b1;
            end else if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign arvalid_o    = w_arvalid;
    assign araddr_o     = r_req_pc;
    assign rready_o     = w_rready;
    assign out_valid_o  = r_out_valid;
    assign out_inst_o   = r_out_inst;
    assign out_pc_o     = r_out_pc;
    assign out_fault_o  = r_out_fault;
    assign fetch_done_o = r_out_valid & out_ready_i & ~flush_i;

`ifdef IFU_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_wait;

    // Completed-fetch and memory-wait counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_wait  <= '0;
        end else begin
            if (fetch_done_o) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (r_state == S_REQ || r_state == S_WAIT) begin
                r_perf_wait <= r_perf_wait + 32'd1;
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_wait_o  = r_perf_wait;
`else
    assign perf_fetch_o = 32'd0;
    assign perf_wait_o  = 32'd0;
`endif

endmodule
